win_scan: RTL and testbench
===========================

WIN_SCAN -- requirements
Module: win_scan

Interface
REQ-001 Parameter PW, default 8, pixel width in bits.
REQ-002 Parameter NPIX, default 12, pixels per line.
REQ-003 Parameter K, default 3, window edge; odd, >=3; PAD=(K-1)/2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset; synchronous, active-low.
REQ-006 start  input  1  capture lines and begin a scan.
REQ-007 line_in  input  K*NPIX*PW  pixel p of line r at bits [(r*NPIX+p)*PW +: PW].
REQ-008 pad_top  input  1  zero window row 0 for this scan.
REQ-009 pad_bot  input  1  zero window row K-1 for this scan.
REQ-010 stride  input  1  0 = column step 1, 1 = column step 2.
REQ-011 win_ready  input  1  consumer accepts win_out.
REQ-012 win_valid  output  1  win_out holds a valid window.
REQ-013 win_out  output  K*K*PW  row r, element j at bits [(r*K+j)*PW +: PW].
REQ-014 win_col  output  clog2(NPIX)  centre column of current window.
REQ-015 win_last  output  1  current window is final of scan.
REQ-016 busy  output  1  scan in progress (SCAN or DONE state).
REQ-017 done  output  1  one-cycle pulse at scan end.

Function
REQ-018 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-019 IDLE + start=1: register line_in, pad_top, pad_bot, stride; column c=0; go SCAN.
REQ-020 start ignored in SCAN and DONE; captured data unchanged.
REQ-021 Window at column c: element j of row r = pixel (c-PAD+j) of line r; index <0 or >NPIX-1 -> zero.
REQ-022 pad_top forces row 0 to zero; pad_bot forces row K-1 to zero; both may be set together.
REQ-023 All outputs registered; win_valid rises the cycle after the start-capture edge.
REQ-024 Column sequence 0, s, 2s, ... while c<=NPIX-1, s=1 or 2; count = NPIX (s=1) or ceil(NPIX/2) (s=2).
REQ-025 Transfer occurs when win_valid=1 and win_ready=1; next window presented the following cycle; throughput one window/cycle.
REQ-026 win_valid=1 and win_ready=0: win_out, win_col, win_last held stable.
REQ-027 win_last=1 exactly on the final column of the sequence.
REQ-028 Transfer with win_last=1: win_valid low next cycle, state DONE, done=1 for that one cycle, then IDLE.
REQ-029 busy=1 in SCAN and DONE, 0 in IDLE.
REQ-030 Column arithmetic wide enough that c+s past NPIX-1 never wraps into a valid column.

Reset
REQ-031 rstn=0 at a rising edge: state IDLE; win_valid, win_out, win_col, win_last, busy, done all 0; captured registers 0.
REQ-032 Reset mid-scan aborts immediately; no done pulse; next start restarts at column 0.
REQ-033 rstn dominates start in the same cycle.

Verification (PW=8, NPIX=12, K=3)
REQ-034 Line0 pixels 0x01..0x0C, lines1/2 zero, stride=0, win_ready=1, start -> 12 windows; row0 col0=0x020100, col1=0x030201, col11=0x000C0B with win_last=1; done pulses next cycle.
REQ-035 All lines 0xFF, pad_bot=1 -> every window row2=0x000000; rows 0/1 interior=0xFFFFFF, col0 row0=0xFFFF00.
REQ-036 win_ready low 3 cycles while win_col=4 -> win_out/win_col held at column 4 for those cycles; column 5 follows the first accepted transfer.
REQ-037 stride=1 -> win_col 0,2,4,6,8,10; win_last at 10; 6 transfers total.
REQ-038 rstn low one cycle while win_col=6 -> next cycle win_valid=0, busy=0, done=0; new start gives win_col=0.
REQ-039 start pulsed with different line_in during SCAN -> ignored; remaining windows match original capture.

Source files
------------

// File: rtl/win_scan_if.sv
// Window stream interface for win_scan.
//   win_valid : producer has a window on win_out
//   win_ready : consumer accepts the window this cycle
//   win_out   : K x K window, row r element j at [(r*K+j)*PW +: PW]
//   win_col   : centre column of the window on win_out
//   win_last  : window on win_out is the final one of the scan
// master = window producer (win_scan), slave = window consumer.
interface win_scan_if #(
    parameter int PW   = 8,
    parameter int NPIX = 12,
    parameter int K    = 3
);
    logic                      win_valid;
    logic                      win_ready;
    logic [K*K*PW-1:0]         win_out;
    logic [$clog2(NPIX)-1:0]   win_col;
    logic                      win_last;

    modport master (
        output win_valid,
        output win_out,
        output win_col,
        output win_last,
        input  win_ready
    );

    modport slave (
        input  win_valid,
        input  win_out,
        input  win_col,
        input  win_last,
        output win_ready
    );
endinterface

// File: rtl/win_scan.sv
// win_scan: captures K image lines on start and emits one K x K window per
// column (step 1 or 2) over a valid/ready stream, zero-filling columns that
// fall outside the line and optionally blanking the top and/or bottom row.
//
// Ports:
//   clk      : single clock, all state on the rising edge
//   rstn     : synchronous active-low reset
//   start    : capture line_in/pad_top/pad_bot/stride and begin a scan (IDLE only)
//   line_in  : K lines, pixel p of line r at [(r*NPIX+p)*PW +: PW]
//   pad_top  : zero window row 0 for this scan
//   pad_bot  : zero window row K-1 for this scan
//   stride   : 0 = column step 1, 1 = column step 2
//   win      : window stream (master side), see win_scan_if
//   busy     : scan in progress (SCAN or DONE)
//   done     : one-cycle pulse when the scan ends
module win_scan #(
    parameter int PW   = 8,
    parameter int NPIX = 12,
    parameter int K    = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [K*NPIX*PW-1:0] line_in,
    input  logic                 pad_top,
    input  logic                 pad_bot,
    input  logic                 stride,
    win_scan_if.master           win,
    output logic                 busy,
    output logic                 done
);
    localparam int PAD = (K - 1) / 2;
    localparam int LW  = K * NPIX * PW;
    localparam int WW  = K * K * PW;
    localparam int CIW = $clog2(NPIX);
    // Two spare bits so col + step past the end of the line never wraps
    // back into a valid column.
    localparam int CW  = CIW + 2;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state_q;
    state_t          state_nxt;

    logic [LW-1:0]   lines_p0;
    logic            pad_top_p0;
    logic            pad_bot_p0;
    logic            stride_p0;
    logic [CW-1:0]   col_p1;

    logic            capture;
    logic [CW-1:0]   col_nxt;
    logic [WW-1:0]   win_nxt;
    logic            valid_nxt;
    logic            last_nxt;
    logic            busy_nxt;
    logic            done_nxt;

    // Assemble the window centred on col; out-of-line pixels and padded rows are zero.
    function automatic logic [WW-1:0] build_win(input logic [LW-1:0] lines,
                                                input logic [CW-1:0] col,
                                                input logic          pt,
                                                input logic          pb);
        logic [WW-1:0] w;
        int            idx;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int j = 0; j < K; j++) begin
                idx = int'(col) - PAD + j;
                if (idx >= 0 && idx < NPIX && !(r == 0 && pt) && !(r == K - 1 && pb))
                    w[(r*K+j)*PW +: PW] = lines[(r*NPIX+idx)*PW +: PW];
            end
        end
        return w;
    endfunction

    function automatic logic [CW-1:0] step_col(input logic [CW-1:0] col, input logic st);
        return col + (st ? CW'(2) : CW'(1));
    endfunction

    // A column is the last one when the next step would leave the line.
    function automatic logic is_last(input logic [CW-1:0] col, input logic st);
        return (int'(col) + (st ? 2 : 1)) > (NPIX - 1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (win.win_valid && win.win_ready && win.win_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; held by default so a stalled
    // window stays stable on the stream.
    always_comb begin
        capture   = 1'b0;
        col_nxt   = col_p1;
        win_nxt   = win.win_out;
        valid_nxt = win.win_valid;
        last_nxt  = win.win_last;
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        unique case (state_q)
            IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (start) begin
                    // First window comes straight from the inputs being captured.
                    capture   = 1'b1;
                    col_nxt   = '0;
                    win_nxt   = build_win(line_in, '0, pad_top, pad_bot);
                    valid_nxt = 1'b1;
                    last_nxt  = is_last('0, stride);
                end
            end
            SCAN: begin
                if (win.win_valid && win.win_ready) begin
                    if (win.win_last) begin
                        valid_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end else begin
                        col_nxt  = step_col(col_p1, stride_p0);
                        win_nxt  = build_win(lines_p0, col_nxt, pad_top_p0, pad_bot_p0);
                        last_nxt = is_last(col_nxt, stride_p0);
                    end
                end
            end
            default: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
            end
        endcase
    end

    // p0: captured scan configuration / p1: current column and output window
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lines_p0      <= '0;
            pad_top_p0    <= 1'b0;
            pad_bot_p0    <= 1'b0;
            stride_p0     <= 1'b0;
            col_p1        <= '0;
            win.win_valid <= 1'b0;
            win.win_out   <= '0;
            win.win_col   <= '0;
            win.win_last  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (capture) begin
                lines_p0   <= line_in;
                pad_top_p0 <= pad_top;
                pad_bot_p0 <= pad_bot;
                stride_p0  <= stride;
            end
            col_p1        <= col_nxt;
            win.win_valid <= valid_nxt;
            win.win_out   <= win_nxt;
            win.win_col   <= col_nxt[CIW-1:0];
            win.win_last  <= last_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end
endmodule

// File: tb/tb_win_scan.sv
module tb_win_scan;
    localparam int PW   = 8;
    localparam int NPIX = 12;
    localparam int K    = 3;
    localparam int PAD  = (K - 1) / 2;
    localparam int LW   = K * NPIX * PW;
    localparam int WW   = K * K * PW;
    localparam int RW   = K * PW;

    typedef struct {
        logic [LW-1:0] lines;
        logic          pt;
        logic          pb;
        logic          st;
        int            pct;        // percent chance win_ready is high
        int            stall_col;  // hold win_ready low 3 cycles here (-1 none)
        int            poke_col;   // pulse start with other data here (-1 none)
        int            exp_cnt;
        int            chk_col;    // column whose rows 0/2 are checked against constants
        logic [RW-1:0] exp_row0;
        logic [RW-1:0] exp_row2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] line_in = '0;
    logic          pad_top = 1'b0;
    logic          pad_bot = 1'b0;
    logic          stride = 1'b0;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    win_scan_if #(.PW(PW), .NPIX(NPIX), .K(K)) wif();

    win_scan #(.PW(PW), .NPIX(NPIX), .K(K)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .line_in (line_in),
        .pad_top (pad_top),
        .pad_bot (pad_bot),
        .stride  (stride),
        .win     (wif),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: zero-extend every line by PAD on both sides, blank padded
    // rows, then the window at column c is simply columns c..c+K-1.
    function automatic logic [WW-1:0] model_win(input logic [LW-1:0] l, input int c,
                                                input logic pt, input logic pb);
        logic [PW-1:0] ext [K][NPIX+2*PAD];
        logic [WW-1:0] w;
        for (int r = 0; r < K; r++)
            for (int x = 0; x < NPIX + 2*PAD; x++)
                ext[r][x] = '0;
        for (int r = 0; r < K; r++)
            for (int p = 0; p < NPIX; p++)
                if (!((r == 0) && pt) && !((r == K-1) && pb))
                    ext[r][p+PAD] = l[(r*NPIX+p)*PW +: PW];
        w = '0;
        for (int r = 0; r < K; r++)
            for (int j = 0; j < K; j++)
                w[(r*K+j)*PW +: PW] = ext[r][c+j];
        return w;
    endfunction

    task automatic do_scan(input vec_t v);
        int   q[$];
        int   xfers, stall_n, cyc;
        logic poked, chk_done, rdy;
        for (int c = 0; c <= NPIX-1; c += (v.st ? 2 : 1)) q.push_back(c);
        line_in = v.lines; pad_top = v.pt; pad_bot = v.pb; stride = v.st;
        wif.win_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("valid_after_start", wif.win_valid, 1'b1);
        xfers = 0; stall_n = 0; cyc = 0; poked = 1'b0; chk_done = 1'b0;
        while (q.size() > 0 && cyc < 400) begin
            cyc++;
            if (wif.win_valid !== 1'b1) begin
                check("valid_in_scan", wif.win_valid, 1'b1);
                break;
            end
            check("win_col", wif.win_col, q[0]);
            check("win_out", wif.win_out, model_win(v.lines, q[0], v.pt, v.pb));
            check("win_last", wif.win_last, q.size() == 1);
            check("busy_scan", busy, 1'b1);
            if (q[0] == v.chk_col && !chk_done) begin
                check("row0_const", wif.win_out[0 +: RW], v.exp_row0);
                check("row2_const", wif.win_out[(K-1)*RW +: RW], v.exp_row2);
                chk_done = 1'b1;
            end
            rdy = ($urandom_range(0, 99) < v.pct);
            if (q[0] == v.stall_col && stall_n < 3) begin
                rdy = 1'b0;
                stall_n++;
            end
            if (q[0] == v.poke_col && !poked) begin
                start   = 1'b1;
                line_in = ~v.lines;
                poked   = 1'b1;
            end
            wif.win_ready = rdy;
            step();
            start   = 1'b0;
            line_in = v.lines;
            if (rdy) begin
                xfers++;
                void'(q.pop_front());
            end
        end
        wif.win_ready = 1'b0;
        check("xfer_count", xfers, v.exp_cnt);
        if (v.chk_col >= 0) check("chk_col_seen", chk_done, 1'b1);
        check("valid_after_last", wif.win_valid, 1'b0);
        check("done_pulse", done, 1'b1);
        check("busy_in_done", busy, 1'b1);
        step();
        check("done_clear", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("valid_idle", wif.win_valid, 1'b0);
    endtask

    initial begin
        logic [LW-1:0] ramp, ones, rl;
        vec_t          tbl[8];
        vec_t          rv;
        int            cyc;

        ramp = '0;
        for (int p = 0; p < NPIX; p++) ramp[p*PW +: PW] = PW'(p + 1);
        ones = '1;

        tbl[0] = '{lines:ramp, pt:1'b0, pb:1'b0, st:1'b0, pct:100, stall_col:-1, poke_col:-1,
                   exp_cnt:12, chk_col:0,  exp_row0:24'h020100, exp_row2:24'h0};
        tbl[1] = '{lines:ramp, pt:1'b0, pb:1'b0, st:1'b0, pct:100, stall_col:4,  poke_col:-1,
                   exp_cnt:12, chk_col:11, exp_row0:24'h000C0B, exp_row2:24'h0};
        tbl[2] = '{lines:ramp, pt:1'b0, pb:1'b0, st:1'b0, pct:70,  stall_col:-1, poke_col:-1,
                   exp_cnt:12, chk_col:1,  exp_row0:24'h030201, exp_row2:24'h0};
        tbl[3] = '{lines:ones, pt:1'b0, pb:1'b1, st:1'b0, pct:100, stall_col:-1, poke_col:-1,
                   exp_cnt:12, chk_col:0,  exp_row0:24'hFFFF00, exp_row2:24'h0};
        tbl[4] = '{lines:ones, pt:1'b0, pb:1'b1, st:1'b0, pct:60,  stall_col:-1, poke_col:-1,
                   exp_cnt:12, chk_col:5,  exp_row0:24'hFFFFFF, exp_row2:24'h0};
        tbl[5] = '{lines:ramp, pt:1'b0, pb:1'b0, st:1'b1, pct:100, stall_col:-1, poke_col:-1,
                   exp_cnt:6,  chk_col:10, exp_row0:24'h0C0B0A, exp_row2:24'h0};
        tbl[6] = '{lines:ramp, pt:1'b0, pb:1'b0, st:1'b0, pct:100, stall_col:-1, poke_col:3,
                   exp_cnt:12, chk_col:7,  exp_row0:24'h090807, exp_row2:24'h0};
        tbl[7] = '{lines:ones, pt:1'b1, pb:1'b1, st:1'b0, pct:80,  stall_col:-1, poke_col:-1,
                   exp_cnt:12, chk_col:3,  exp_row0:24'h0,      exp_row2:24'h0};

        wif.win_ready = 1'b0;

        // Reset, with start asserted at the same time: reset must win.
        rstn  = 1'b0;
        start = 1'b1;
        line_in = ramp;
        step();
        step();
        start = 1'b0;
        check("rst_valid", wif.win_valid, 1'b0);
        check("rst_out", wif.win_out, '0);
        check("rst_col", wif.win_col, '0);
        check("rst_last", wif.win_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rstn = 1'b1;
        step();
        check("idle_after_rst_start", wif.win_valid, 1'b0);

        for (int i = 0; i < 8; i++) do_scan(tbl[i]);

        // Reset in the middle of a scan aborts without a done pulse.
        line_in = ramp; pad_top = 1'b0; pad_bot = 1'b0; stride = 1'b0;
        wif.win_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (wif.win_col != 6 && cyc < 50) begin
            step();
            cyc++;
        end
        check("reach_col6", wif.win_col, 6);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        wif.win_ready = 1'b0;
        check("abort_valid", wif.win_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_col", wif.win_col, '0);
        step();
        check("abort_no_done", done, 1'b0);
        check("abort_idle_valid", wif.win_valid, 1'b0);
        do_scan(tbl[0]);

        // Randomised scans against the reference model.
        for (int n = 0; n < 8; n++) begin
            rl = '0;
            for (int p = 0; p < K*NPIX; p++) rl[p*PW +: PW] = PW'($urandom);
            rv.lines     = rl;
            rv.pt        = 1'($urandom_range(0, 1));
            rv.pb        = 1'($urandom_range(0, 1));
            rv.st        = 1'($urandom_range(0, 1));
            rv.pct       = 50;
            rv.stall_col = -1;
            rv.poke_col  = (n % 2 == 0) ? 2 : -1;
            rv.exp_cnt   = rv.st ? (NPIX + 1) / 2 : NPIX;
            rv.chk_col   = -1;
            rv.exp_row0  = '0;
            rv.exp_row2  = '0;
            do_scan(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
